// File: rtl/sound_event_arbiter.sv
// sound_event_arbiter
//
// Picks one of NUM_EVENTS sound event sources and plays its code for a
// number of video frames. Index 0 has the highest priority. A sound that
// ends is always followed by at least one silent frame (GAP state).
//
// Optional feature: define SOUND_QUEUE_EN to remember requests that could
// not be served (lower priority than the playing sound, or arriving during
// the silent gap) in the pending vector. Without it those requests are
// dropped and pending reads 0.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   frame_start  one-cycle pulse per video frame
//   event_req    one-cycle request pulse per source
//   event_code   packed codes, source i at [i*CODE_W +: CODE_W]
//   event_dur    packed durations in frames, source i at [i*DUR_W +: DUR_W]
//   enable_sound high while a sound plays
//   sound        code of the playing sound, 0 when silent
//   active_id    index of the playing source, 0 when silent
//   pending      latched requests not yet served
//   fsm_state    current state (0 IDLE, 1 PLAY, 2 GAP) for observation
module sound_event_arbiter #(
    parameter int NUM_EVENTS = 4,
    parameter int CODE_W     = 4,
    parameter int DUR_W      = 5,
    localparam int ID_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [NUM_EVENTS-1:0]        event_req,
    input  logic [NUM_EVENTS*CODE_W-1:0] event_code,
    input  logic [NUM_EVENTS*DUR_W-1:0]  event_dur,
    output logic                         enable_sound,
    output logic [CODE_W-1:0]            sound,
    output logic [ID_W-1:0]              active_id,
    output logic [NUM_EVENTS-1:0]        pending,
    output logic [1:0]                   fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

`ifdef SOUND_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    state_t                  state;
    logic [DUR_W-1:0]        timer;

    logic [CODE_W-1:0]       code_arr [NUM_EVENTS];
    logic [DUR_W-1:0]        dur_arr  [NUM_EVENTS];
    logic [NUM_EVENTS-1:0]   dur_nz;
    logic [NUM_EVENTS-1:0]   req_valid;
    logic [NUM_EVENTS-1:0]   cand;

    logic                    win_found;
    logic [ID_W-1:0]         win_idx;
    logic [NUM_EVENTS-1:0]   win_mask;
    logic                    pre_found;
    logic [ID_W-1:0]         pre_idx;
    logic [NUM_EVENTS-1:0]   pre_mask;
    logic [NUM_EVENTS-1:0]   active_mask;
    logic                    preempt;
    logic                    restart;

    assign fsm_state = state;

    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            code_arr[i] = event_code[i*CODE_W +: CODE_W];
            dur_arr[i]  = event_dur[i*DUR_W +: DUR_W];
            dur_nz[i]   = |event_dur[i*DUR_W +: DUR_W];
        end
    end

    // Zero-duration requests are invisible everywhere, including pending.
    assign req_valid = event_req & dur_nz;
    assign cand      = (event_req | pending) & dur_nz;

    // Two lowest-index encoders: cand picks who starts from IDLE/GAP,
    // req_valid alone decides preemption/restart while playing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pre_found = 1'b0;
        pre_idx   = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
            if (req_valid[i]) begin
                pre_found = 1'b1;
                pre_idx   = ID_W'(i);
            end
        end
    end

    assign win_mask    = win_found ? (NUM_EVENTS'(1) << win_idx) : '0;
    assign pre_mask    = NUM_EVENTS'(1) << pre_idx;
    assign active_mask = NUM_EVENTS'(1) << active_id;
    assign preempt     = pre_found && (pre_idx < active_id);
    assign restart     = req_valid[active_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            pending      <= '0;
            enable_sound <= 1'b0;
            sound        <= '0;
            active_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // frame_start is ignored here: the load cycle never counts.
                    if (win_found) begin
                        state        <= PLAY;
                        timer        <= dur_arr[win_idx];
                        sound        <= code_arr[win_idx];
                        active_id    <= win_idx;
                        enable_sound <= 1'b1;
                    end
                    pending <= QUEUE_EN ? ((pending | req_valid) & ~win_mask) : '0;
                end

                PLAY: begin
                    if (preempt) begin
                        // Preemption beats a simultaneous end-of-sound; the
                        // preempted source is simply forgotten.
                        timer     <= dur_arr[pre_idx];
                        sound     <= code_arr[pre_idx];
                        active_id <= pre_idx;
                        pending   <= QUEUE_EN ? ((pending | req_valid) & ~pre_mask) : '0;
                    end else begin
                        if (restart) begin
                            timer <= dur_arr[active_id];
                        end else if (frame_start) begin
                            if (timer == DUR_W'(1)) begin
                                state        <= GAP;
                                timer        <= '0;
                                enable_sound <= 1'b0;
                                sound        <= '0;
                                active_id    <= '0;
                            end else if (timer != '0) begin
                                timer <= timer - DUR_W'(1);
                            end
                        end
                        pending <= QUEUE_EN ? (pending | (req_valid & ~active_mask)) : '0;
                    end
                end

                GAP: begin
                    if (frame_start && QUEUE_EN && win_found) begin
                        state        <= PLAY;
                        timer        <= dur_arr[win_idx];
                        sound        <= code_arr[win_idx];
                        active_id    <= win_idx;
                        enable_sound <= 1'b1;
                        pending      <= (pending | req_valid) & ~win_mask;
                    end else begin
                        if (frame_start) begin
                            state <= IDLE;
                        end
                        pending <= QUEUE_EN ? (pending | req_valid) : '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// tb_sound_event_arbiter
//
// Bench for sound_event_arbiter with default parameters. Each cycle of
// stimulus pushes the output vector expected after the next rising edge;
// a negedge monitor pops and compares against the DUT.
// Expected vector layout: {state[1:0], enable, sound[3:0], id[1:0], pending[3:0]}.
module tb_sound_event_arbiter;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int DW = 5;

`ifdef SOUND_QUEUE_EN
    localparam bit Q = 1'b1;
`else
    localparam bit Q = 1'b0;
`endif

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_P = 2'd1;
    localparam logic [1:0] ST_G = 2'd2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            frame_start = 1'b0;
    logic [N-1:0]    event_req = '0;
    logic [N*CW-1:0] event_code;
    logic [N*DW-1:0] event_dur;
    logic            enable_sound;
    logic [CW-1:0]   sound;
    logic [1:0]      active_id;
    logic [N-1:0]    pending;
    logic [1:0]      fsm_state;

    logic [12:0] exp_q[$];
    string       name_q[$];
    string       cur_test;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [12:0] mon_exp;
    logic [12:0] mon_act;
    string       mon_name;
    logic [3:0]  code1;

    sound_event_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .event_req    (event_req),
        .event_code   (event_code),
        .event_dur    (event_dur),
        .enable_sound (enable_sound),
        .sound        (sound),
        .active_id    (active_id),
        .pending      (pending),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [12:0] pk(input logic [1:0] st, input logic en,
                                       input logic [3:0] snd, input logic [1:0] id,
                                       input logic [3:0] pend);
        return {st, en, snd, id, pend};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {fsm_state, enable_sound, sound, active_id, pending};
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got state=%0d en=%b sound=%h id=%0d pending=%b, expected state=%0d en=%b sound=%h id=%0d pending=%b",
                         mon_name, $time,
                         mon_act[12:11], mon_act[10], mon_act[9:6], mon_act[5:4], mon_act[3:0],
                         mon_exp[12:11], mon_exp[10], mon_exp[9:6], mon_exp[5:4], mon_exp[3:0]);
            end
        end
    end

    // driver: one clock cycle of inputs plus the outputs expected after its edge
    task automatic drive(input logic [3:0] req, input logic fs, input logic rst,
                         input logic [12:0] exp);
        @(negedge clk);
        #1;
        event_req   = req;
        frame_start = fs;
        reset       = rst;
        exp_q.push_back(exp);
        name_q.push_back(cur_test);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
    endtask

    task automatic test_reset();
        cur_test = "reset";
        drive(4'b0000, 1'b0, 1'b1, pk(ST_I, 0, 0, 0, 0));
        drive(4'b0110, 1'b1, 1'b1, pk(ST_I, 0, 0, 0, 0));
        drive(4'b0000, 1'b0, 1'b0, pk(ST_I, 0, 0, 0, 0));
    endtask

    task automatic test_basic();
        cur_test = "basic";
        drive(4'b0010, 1'b0, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b0, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
        drive(4'b0000, 1'b0, 1'b0, pk(ST_G, 0, 0, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
    endtask

    task automatic test_preempt();
        cur_test = "preempt";
        drive(4'b0100, 1'b0, 1'b0, pk(ST_P, 1, 4'hC, 2, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'hC, 2, 0));
        drive(4'b0001, 1'b0, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
    endtask

    task automatic test_preempt_at_end();
        cur_test = "preempt_at_end";
        drive(4'b0010, 1'b0, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0001, 1'b1, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
    endtask

    task automatic test_restart();
        cur_test = "restart";
        drive(4'b0010, 1'b0, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0010, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
    endtask

    task automatic test_queue();
        logic [3:0] p3;
        cur_test = "queue";
        p3 = Q ? 4'b1000 : 4'b0000;
        drive(4'b0001, 1'b0, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b1000, 1'b0, 1'b0, pk(ST_P, 1, 4'h4, 0, p3));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h4, 0, p3));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, p3));
        drive(4'b0000, 1'b0, 1'b0, pk(ST_G, 0, 0, 0, p3));
        if (Q) begin
            drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h9, 3, 0));
            drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h9, 3, 0));
            drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
            drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
        end else begin
            idle_n(4);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] p3;
        cur_test = "simultaneous";
        p3 = Q ? 4'b1000 : 4'b0000;
        drive(4'b1010, 1'b0, 1'b0, pk(ST_P, 1, code1, 1, p3));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, p3));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, p3));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, p3));
        if (Q) begin
            drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h9, 3, 0));
            drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h9, 3, 0));
            drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
            drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
        end else begin
            idle_n(4);
        end
    endtask

    task automatic test_gap_latch();
        cur_test = "gap_latch";
        drive(4'b0001, 1'b0, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
        drive(4'b0100, 1'b0, 1'b0, pk(ST_G, 0, 0, 0, Q ? 4'b0100 : 4'b0000));
        if (Q) begin
            drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'hC, 2, 0));
            for (int i = 0; i < 4; i++) drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'hC, 2, 0));
            drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
            drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
        end else begin
            idle_n(2);
        end
    endtask

    task automatic test_dur_edges();
        cur_test = "dur_one";
        event_dur[1*DW +: DW] = 5'd1;
        drive(4'b0010, 1'b1, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b0, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b0, 1'b0, pk(ST_P, 1, code1, 1, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
        cur_test = "dur_zero";
        event_dur[2*DW +: DW] = 5'd0;
        drive(4'b0100, 1'b0, 1'b0, pk(ST_I, 0, 0, 0, 0));
        drive(4'b0000, 1'b0, 1'b0, pk(ST_I, 0, 0, 0, 0));
        drive(4'b0001, 1'b0, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0100, 1'b0, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_I, 0, 0, 0, 0));
        event_dur[1*DW +: DW] = 5'd3;
        event_dur[2*DW +: DW] = 5'd5;
    endtask

    task automatic test_reset_mid();
        cur_test = "reset_mid_play";
        drive(4'b0001, 1'b0, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b1000, 1'b0, 1'b0, pk(ST_P, 1, 4'h4, 0, Q ? 4'b1000 : 4'b0000));
        drive(4'b0010, 1'b1, 1'b1, pk(ST_I, 0, 0, 0, 0));
        drive(4'b0000, 1'b0, 1'b0, pk(ST_I, 0, 0, 0, 0));
        cur_test = "reset_mid_gap";
        drive(4'b0001, 1'b0, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_P, 1, 4'h4, 0, 0));
        drive(4'b0000, 1'b1, 1'b0, pk(ST_G, 0, 0, 0, 0));
        drive(4'b0100, 1'b1, 1'b1, pk(ST_I, 0, 0, 0, 0));
        drive(4'b0000, 1'b0, 1'b0, pk(ST_I, 0, 0, 0, 0));
    endtask

    initial begin
        code1 = 4'($urandom_range(1, 15));
        event_code = {4'h9, 4'hC, code1, 4'h4};
        event_dur  = {5'd2, 5'd5, 5'd3, 5'd2};
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_preempt();
        test_preempt_at_end();
        test_restart();
        test_queue();
        test_simultaneous();
        test_gap_latch();
        test_dur_edges();
        test_reset_mid();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
